ysyx_25030085_mem_responder: RTL and testbench

Memory-side responder for the core's load/store port: accepts one word-aligned read or write request over a valid/ready channel, performs the access against simulated physical memory through the `pmem_readv` / `pmem_write` DPI functions after a configurable delay, and returns the result over a valid/ready response channel. It sits between the LSU request port and the DPI memory model. It replaces the zero-latency direct DPI call, so the LSU can be exercised against multi-cycle memory.

---
 rtl/ysyx_25030085_mem_pkg.sv | 59 +++++
 rtl/ysyx_25030085_delay_lfsr.sv | 24 ++
 rtl/ysyx_25030085_mem_responder.sv | 107 ++++++++++
 tb/tb_ysyx_25030085_mem_responder.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25030085_mem_pkg.sv
// Shared state encoding, bus widths and LFSR seed for the memory responder, plus the
// behavioural physical-memory model that pmem_readv/pmem_write resolve to in simulation.
package ysyx_25030085_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_RESP
  } state_t;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_MASK_W = 4;

  localparam logic [3:0] LFSR_SEED = 4'b1001;

  // Sparse word-keyed memory; words never written read back as zero.
  logic [MEM_DATA_W-1:0] pmem_words [logic [MEM_ADDR_W-1:0]];
  int unsigned           pmem_read_calls;
  int unsigned           pmem_write_calls;
  logic [MEM_ADDR_W-1:0] pmem_last_addr;
  logic [MEM_DATA_W-1:0] pmem_last_wdata;
  logic [7:0]            pmem_last_wmask;

  function automatic logic [MEM_ADDR_W-1:0] pmem_key(input logic [MEM_ADDR_W-1:0] addr);
    return addr & ~32'h3;
  endfunction

  function automatic logic [MEM_DATA_W-1:0] pmem_peek(input logic [MEM_ADDR_W-1:0] addr);
    return pmem_words.exists(pmem_key(addr)) ? pmem_words[pmem_key(addr)] : '0;
  endfunction

  function automatic void pmem_poke(input logic [MEM_ADDR_W-1:0] addr,
                                    input logic [MEM_DATA_W-1:0] data);
    pmem_words[pmem_key(addr)] = data;
  endfunction

  function automatic logic [MEM_DATA_W-1:0] pmem_readv(input logic [MEM_ADDR_W-1:0] addr);
    pmem_read_calls = pmem_read_calls + 1;
    pmem_last_addr  = addr;
    return pmem_peek(addr);
  endfunction

  function automatic void pmem_write(input logic [MEM_ADDR_W-1:0] addr,
                                     input logic [MEM_DATA_W-1:0] wdata,
                                     input logic [7:0]            wmask);
    logic [MEM_DATA_W-1:0] word;
    word = pmem_peek(addr);
    for (int b = 0; b < MEM_MASK_W; b++)
      if (wmask[b]) word[8*b +: 8] = wdata[8*b +: 8];
    pmem_words[pmem_key(addr)] = word;
    pmem_write_calls = pmem_write_calls + 1;
    pmem_last_addr   = addr;
    pmem_last_wdata  = wdata;
    pmem_last_wmask  = wmask;
  endfunction

endpackage

// File: rtl/ysyx_25030085_delay_lfsr.sv
// 4-bit LFSR (x^4+x^3+1) that steps once per accepted request; its low two bits
// give the extra per-request delay of 0-3 cycles.
module ysyx_25030085_delay_lfsr
  import ysyx_25030085_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       advance,
  output logic [1:0] extra
);

  logic [3:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
    end else if (advance) begin
      lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
    end
  end

  assign extra = lfsr[1:0];

endmodule

// File: rtl/ysyx_25030085_mem_responder.sv
// Single-outstanding LSU memory responder: captures a request, waits LATENCY (+ random extra)
// cycles, performs the pmem access in one ACCESS cycle, then holds the response until taken.
module ysyx_25030085_mem_responder
  import ysyx_25030085_mem_pkg::*;
#(
  parameter int LATENCY    = 1,
  parameter int RAND_DELAY = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [MEM_ADDR_W-1:0] req_addr,
  input  logic [MEM_DATA_W-1:0] req_wdata,
  input  logic [MEM_MASK_W-1:0] req_wmask,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [MEM_DATA_W-1:0] resp_rdata,
  output logic                  resp_err
);

  state_t                state;
  logic [4:0]            cnt;
  logic                  wen_q;
  logic [MEM_ADDR_W-1:0] addr_q;
  logic [MEM_DATA_W-1:0] wdata_q;
  logic [MEM_MASK_W-1:0] wmask_q;
  logic                  accept;
  logic [1:0]            extra;
  logic [4:0]            delay;

  assign accept = (state == ST_IDLE) && req_valid && req_ready;
  assign delay  = 5'(LATENCY) + {3'b000, extra};

  generate
    if (RAND_DELAY == 1) begin : g_rand
      ysyx_25030085_delay_lfsr u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (accept),
        .extra   (extra)
      );
    end else begin : g_fixed
      assign extra = 2'b00;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      cnt        <= '0;
      wen_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            wen_q     <= req_wen;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            wmask_q   <= req_wmask;
            req_ready <= 1'b0;
            if (delay == 5'd0) begin
              state <= ST_ACCESS;
            end else begin
              state <= ST_WAIT;
              cnt   <= delay - 5'd1;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (cnt == 5'd0) state <= ST_ACCESS;
          else             cnt   <= cnt - 5'd1;
        end
        ST_ACCESS: begin
          state      <= ST_RESP;
          resp_rdata <= '0;
          resp_err   <= 1'b0;
          // Misaligned requests never reach memory; the error rides the normal response path.
          if (addr_q[1:0] != 2'b00)    resp_err   <= 1'b1;
          else if (!wen_q)             resp_rdata <= pmem_readv(addr_q);
          else if (wmask_q != '0)      pmem_write(addr_q, wdata_q, {4'b0000, wmask_q});
        end
        ST_RESP: begin
          if (!resp_valid) begin
            resp_valid <= 1'b1;
          end else if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25030085_mem_responder.sv
// Bench for the memory responder: four instances (LATENCY 0/3/2 and 1 with random delay)
// driven by a vector table, hand sequences for reset corners, and a random phase.
module tb_ysyx_25030085_mem_responder;
  import ysyx_25030085_mem_pkg::*;

  localparam int NI = 4;

  logic                clk   = 1'b0;
  logic                rst_n = 1'b1;
  logic [NI-1:0]       req_valid, req_ready, req_wen, resp_valid, resp_ready, resp_err;
  logic [NI-1:0][31:0] req_addr, req_wdata, resp_rdata;
  logic [NI-1:0][3:0]  req_wmask;

  int compared   = 0;
  int mismatched = 0;

  int         lat_tab [NI] = '{0, 3, 2, 1};
  // Low two bits of the x^4+x^3+1 state sequence starting at seed 1001.
  logic [1:0] extra_seq [15] = '{2'd1, 2'd3, 2'd2, 2'd1, 2'd2, 2'd1, 2'd3, 2'd3,
                                 2'd3, 2'd2, 2'd0, 2'd0, 2'd1, 2'd2, 2'd0};
  int         lfsr_pos = 0;
  logic [31:0] ref_mem [logic [31:0]];

  typedef struct {
    int          inst;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          hold;
    bit          early;
  } vec_t;

  vec_t vecs [13];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    ysyx_25030085_mem_responder #(
      .LATENCY    ((g == 0) ? 0 : (g == 1) ? 3 : (g == 2) ? 2 : 1),
      .RAND_DELAY ((g == 3) ? 1 : 0)
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_wen    (req_wen[g]),
      .req_addr   (req_addr[g]),
      .req_wdata  (req_wdata[g]),
      .req_wmask  (req_wmask[g]),
      .resp_valid (resp_valid[g]),
      .resp_ready (resp_ready[g]),
      .resp_rdata (resp_rdata[g]),
      .resp_err   (resp_err[g])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: got no handshake within bound, want handshake", name);
  endtask

  function automatic vec_t mk(int inst, logic wen, logic [31:0] addr, logic [31:0] wdata,
                              logic [3:0] mask, logic [31:0] er, logic ee, int hold, bit early);
    vec_t v;
    v.inst = inst; v.wen = wen; v.addr = addr; v.wdata = wdata; v.mask = mask;
    v.exp_rdata = er; v.exp_err = ee; v.hold = hold; v.early = early;
    return v;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] k;
    k = {a[31:2], 2'b00};
    return ref_mem.exists(k) ? ref_mem[k] : 32'h0;
  endfunction

  function automatic void ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] w;
    w = ref_word(a);
    for (int b = 0; b < 4; b++)
      if (m[b]) w[8*b +: 8] = d[8*b +: 8];
    ref_mem[{a[31:2], 2'b00}] = w;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    ref_mem[a] = d;
    pmem_poke(a, d);
  endtask

  task automatic transact(input int i, input string name, input logic wen, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] mask, input logic [31:0] exp_rdata,
                          input logic exp_err, input int exp_edges, input int hold, input bit early);
    int unsigned rd0, wr0;
    int          n, t, exp_rd, exp_wr;
    exp_rd = (addr[1:0] == 2'b00 && !wen) ? 1 : 0;
    exp_wr = (addr[1:0] == 2'b00 && wen && mask != 4'h0) ? 1 : 0;
    rd0 = pmem_read_calls;
    wr0 = pmem_write_calls;
    @(negedge clk);
    req_valid[i] = 1'b1; req_wen[i] = wen; req_addr[i] = addr;
    req_wdata[i] = wdata; req_wmask[i] = mask;
    t = 0;
    while (!req_ready[i] && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready[i]) begin
      fail_timeout({name, " accept"});
      req_valid[i] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    req_wen[i]   = 1'($urandom);
    req_addr[i]  = $urandom;
    req_wdata[i] = $urandom;
    req_wmask[i] = 4'($urandom);
    if (early) resp_ready[i] = 1'b1;
    check({name, " req_ready after accept"}, 32'(req_ready[i]), 32'd0);
    n = 0;
    while (!resp_valid[i] && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (!resp_valid[i]) begin
      fail_timeout({name, " response"});
      resp_ready[i] = 1'b0;
      return;
    end
    check({name, " latency"}, 32'(n), 32'(exp_edges));
    check({name, " rdata"}, resp_rdata[i], exp_rdata);
    check({name, " err"}, 32'(resp_err[i]), 32'(exp_err));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      req_valid[i] = 1'b1; req_wen[i] = 1'b0; req_addr[i] = 32'h8000_0000;
      @(posedge clk); #1;
      check({name, " hold valid"}, 32'(resp_valid[i]), 32'd1);
      check({name, " hold rdata"}, resp_rdata[i], exp_rdata);
      check({name, " hold err"}, 32'(resp_err[i]), 32'(exp_err));
      check({name, " hold req_ready"}, 32'(req_ready[i]), 32'd0);
    end
    @(negedge clk);
    req_valid[i]  = 1'b0;
    resp_ready[i] = 1'b1;
    @(posedge clk); #1;
    resp_ready[i] = 1'b0;
    check({name, " valid after handshake"}, 32'(resp_valid[i]), 32'd0);
    check({name, " ready after handshake"}, 32'(req_ready[i]), 32'd1);
    check({name, " read calls"}, 32'(pmem_read_calls - rd0), 32'(exp_rd));
    check({name, " write calls"}, 32'(pmem_write_calls - wr0), 32'(exp_wr));
    if (exp_wr == 1) begin
      check({name, " write addr"}, pmem_last_addr, addr);
      check({name, " write data"}, pmem_last_wdata, wdata);
      check({name, " write mask"}, 32'(pmem_last_wmask), {28'd0, mask});
    end else if (exp_rd == 1) begin
      check({name, " read addr"}, pmem_last_addr, addr);
    end
  endtask

  task automatic random_phase();
    int          i;
    logic        wen, err;
    logic [31:0] addr, wdata, er;
    logic [3:0]  mask;
    int          edges;
    for (int r = 0; r < 40; r++) begin
      i     = $urandom_range(0, NI - 1);
      wen   = 1'($urandom_range(0, 1));
      addr  = 32'h8000_0000 + 32'(4 * $urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) addr[1:0] = 2'($urandom_range(1, 3));
      wdata = $urandom;
      mask  = 4'($urandom);
      err   = (addr[1:0] != 2'b00);
      er    = (err || wen) ? 32'h0 : ref_word(addr);
      edges = lat_tab[i] + 2;
      if (i == 3) begin
        edges    = edges + int'(extra_seq[lfsr_pos]);
        lfsr_pos = (lfsr_pos + 1) % 15;
      end
      transact(i, $sformatf("rnd%0d", r), wen, addr, wdata, mask, er, err, edges,
               $urandom_range(0, 2), 1'b0);
      if (wen && !err) ref_write(addr, wdata, mask);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, want end before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    req_valid = '0; resp_ready = '0; req_wen = '0;
    req_addr = '0; req_wdata = '0; req_wmask = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset req_ready", 32'(req_ready), 32'h0);
    check("reset resp_valid", 32'(resp_valid), 32'h0);
    check("reset resp_err", 32'(resp_err), 32'h0);
    check("reset rdata0", resp_rdata[0], 32'h0);
    rst_n = 1'b1;
    #1 check("ready before first edge", 32'(req_ready), 32'h0);
    @(posedge clk); #1;
    check("ready after first edge", 32'(req_ready), 32'hF);
    check("idle resp_valid", 32'(resp_valid), 32'h0);

    preload(32'h8000_0004, 32'h1122_3344);
    preload(32'h8000_0008, 32'hCAFE_F00D);
    preload(32'h8000_000C, 32'h55AA_55AA);

    vecs[0]  = mk(0, 1'b1, 32'h8000_0000, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0, 0, 1'b0);
    vecs[1]  = mk(0, 1'b0, 32'h8000_0000, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0, 1, 1'b0);
    vecs[2]  = mk(0, 1'b1, 32'h8000_0004, 32'h0000_AB00, 4'h2, 32'h0,         1'b0, 0, 1'b0);
    vecs[3]  = mk(0, 1'b0, 32'h8000_0004, 32'h0,         4'h0, 32'h1122_AB44, 1'b0, 0, 1'b0);
    vecs[4]  = mk(1, 1'b0, 32'h8000_0000, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0, 4, 1'b0);
    vecs[5]  = mk(0, 1'b1, 32'h8000_0002, 32'h1234_5678, 4'hF, 32'h0,         1'b1, 1, 1'b0);
    vecs[6]  = mk(0, 1'b0, 32'h8000_0000, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0, 0, 1'b0);
    vecs[7]  = mk(0, 1'b1, 32'h8000_000C, 32'hFFFF_FFFF, 4'h0, 32'h0,         1'b0, 0, 1'b0);
    vecs[8]  = mk(0, 1'b0, 32'h8000_000C, 32'h0,         4'h0, 32'h55AA_55AA, 1'b0, 0, 1'b0);
    vecs[9]  = mk(1, 1'b0, 32'h8000_0001, 32'h0,         4'h0, 32'h0,         1'b1, 2, 1'b0);
    vecs[10] = mk(2, 1'b1, 32'h8000_0010, 32'hAABB_CCDD, 4'hC, 32'h0,         1'b0, 0, 1'b0);
    vecs[11] = mk(2, 1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'hAABB_0000, 1'b0, 1, 1'b0);
    vecs[12] = mk(1, 1'b0, 32'h8000_0004, 32'h0,         4'h0, 32'h1122_AB44, 1'b0, 0, 1'b1);

    foreach (vecs[v]) begin
      transact(vecs[v].inst, $sformatf("vec%0d", v), vecs[v].wen, vecs[v].addr, vecs[v].wdata,
               vecs[v].mask, vecs[v].exp_rdata, vecs[v].exp_err, lat_tab[vecs[v].inst] + 2,
               vecs[v].hold, vecs[v].early);
      if (vecs[v].wen && vecs[v].addr[1:0] == 2'b00)
        ref_write(vecs[v].addr, vecs[v].wdata, vecs[v].mask);
    end

    // Reset one cycle after accepting a write: the write must never reach memory.
    begin
      int unsigned wr0;
      @(negedge clk);
      req_valid[2] = 1'b1; req_wen[2] = 1'b1; req_addr[2] = 32'h8000_0008;
      req_wdata[2] = 32'h0BAD_BAD0; req_wmask[2] = 4'hF;
      t = 0;
      while (!req_ready[2] && t < 20) begin @(negedge clk); t++; end
      if (!req_ready[2]) fail_timeout("rst_wait accept");
      wr0 = pmem_write_calls;
      @(posedge clk); #1;
      req_valid[2] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_wait req_ready", 32'(req_ready[2]), 32'd0);
      check("rst_wait resp_valid", 32'(resp_valid[2]), 32'd0);
      check("rst_wait rdata", resp_rdata[2], 32'h0);
      check("rst_wait err", 32'(resp_err[2]), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      lfsr_pos = 0;
      repeat (5) @(posedge clk);
      #1 check("rst_wait no write", 32'(pmem_write_calls - wr0), 32'd0);
      transact(2, "rst_wait reread", 1'b0, 32'h8000_0008, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0,
               lat_tab[2] + 2, 0, 1'b0);
    end

    // Reset while a response is pending drops it.
    begin
      @(negedge clk);
      req_valid[0] = 1'b1; req_wen[0] = 1'b0; req_addr[0] = 32'h8000_0004;
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      t = 0;
      while (!resp_valid[0] && t < 20) begin @(posedge clk); #1; t++; end
      if (!resp_valid[0]) fail_timeout("rst_resp response");
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_resp resp_valid", 32'(resp_valid[0]), 32'd0);
      check("rst_resp rdata", resp_rdata[0], 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      lfsr_pos = 0;
    end

    random_phase();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
